// File: rtl/seg7_scan_driver_pkg.sv
// ============================================================================
//  Module      : seg7_scan_driver_pkg
//  Description : Shared segment patterns, digit constants and small helpers
//                for the seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seg7_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are zero
    function automatic logic lz_blanked(input logic [15:0] word,
                                        input logic [1:0]  idx,
                                        input logic        en);
        logic [15:0] upper;
        upper = word >> {idx, 2'b00};
        return en && (idx != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational hex nibble to active-low seven-segment decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Four-digit multiplexed seven-segment driver with a
//                frame-synchronous double-buffered display word.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        blank_lz,
    input  logic [3:0]  dp_in,
    output logic [3:0]  Anode,
    output logic [6:0]  Cathode,
    output logic        dp,
    output logic        busy,
    output logic        frame_done
);

    localparam int                c_PW   = $clog2(REFRESH_DIV);
    localparam int                c_IDXW = $clog2(NUM_DIGITS);
    localparam logic [c_PW-1:0]   c_PMAX = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NUM_DIGITS - 1);

    logic [c_PW-1:0]   r_presc;
    logic [c_IDXW-1:0] r_idx;
    logic [15:0]       r_shadow;
    logic [15:0]       r_disp;
    logic              r_pending;
    logic [3:0]        r_anode;
    logic [6:0]        r_cathode;
    logic              r_dp;
    logic              r_frame_done;

    logic              w_tick;
    logic              w_boundary;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg;
    logic              w_blank;

    assign w_tick     = (r_presc == c_PMAX);
    assign w_boundary = w_tick && (r_idx == c_LAST);
    assign w_nibble   = r_disp[{r_idx, 2'b00} +: 4];
    assign w_blank    = lz_blanked(r_disp, r_idx, blank_lz);

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_shadow     <= 16'h0000;
            r_disp       <= 16'h0000;
            r_pending    <= 1'b0;
            r_anode      <= ANODE_OFF;
            r_cathode    <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end

            // A strobe landing on the boundary bypasses the shadow wait
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (data_valid) begin
                    r_disp   <= data_in;
                    r_shadow <= data_in;
                end else if (r_pending) begin
                    r_disp <= r_shadow;
                end
            end else if (data_valid) begin
                r_shadow  <= data_in;
                r_pending <= 1'b1;
            end

            r_anode      <= anode_sel(r_idx);
            r_cathode    <= w_blank ? SEG_BLANK : w_seg;
            r_dp         <= ~dp_in[r_idx];
            r_frame_done <= w_boundary;
        end
    end

    assign Anode      = r_anode;
    assign Cathode    = r_cathode;
    assign dp         = r_dp;
    assign busy       = r_pending;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
